// File: rtl/coarse_delay_buffer_if.sv
// Sample-stream and delay-control bundle of the coarse delay stage.
// The master drives samples and the delay register value; the slave
// returns the delayed stream plus delay status.
interface coarse_delay_buffer_if #(
   parameter int ADDR_BITS  = 10,
   parameter int DATA_WIDTH = 32
);
   logic [31:0]           delay_reg;
   logic                  sync_in;
   logic [DATA_WIDTH-1:0] din;
   logic                  din_valid;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic                  sync_out;
   logic [ADDR_BITS-1:0]  delay_active;
   logic                  delay_pending;
   logic                  delay_err;

   modport master (
      output delay_reg, sync_in, din, din_valid,
      input  dout, dout_valid, sync_out, delay_active, delay_pending, delay_err
   );

   modport slave (
      input  delay_reg, sync_in, din, din_valid,
      output dout, dout_valid, sync_out, delay_active, delay_pending, delay_err
   );
endinterface

// File: rtl/coarse_delay_buffer.sv
// Integer-sample coarse delay stage. Samples are written into a circular
// RAM at wr_ptr and read back at wr_ptr - delay. A new delay requested by
// software is held pending and only applied on a valid sync sample, so all
// channels switch on the same frame boundary. Output latency is a fixed
// two cycles (RAM read register + output register).
module coarse_delay_buffer #(
   parameter int ADDR_BITS  = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  user_clk,
   input  logic                  user_rst_n,
   coarse_delay_buffer_if.slave  bus
);

   localparam int                   DEPTH     = 1 << ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] MAX_DELAY = {ADDR_BITS{1'b1}};
   localparam logic [ADDR_BITS-1:0] ONE       = ADDR_BITS'(1);
   localparam logic [ADDR_BITS-1:0] ZERO      = {ADDR_BITS{1'b0}};

   // ---------------- control state ----------------
   logic [31:0]           req_q,         req_d;
   logic [31:0]           req_prev_q,    req_prev_d;
   logic [ADDR_BITS-1:0]  pending_val_q, pending_val_d;
   logic                  pending_q,     pending_d;
   logic                  err_q,         err_d;
   logic [ADDR_BITS-1:0]  active_q,      active_d;
   logic [ADDR_BITS-1:0]  wr_ptr_q,      wr_ptr_d;
   logic [ADDR_BITS-1:0]  fill_q,        fill_d;

   // ---------------- stage 1 (alongside RAM read) ----------------
   logic [DATA_WIDTH-1:0] din1_q,        din1_d;
   logic                  valid1_q,      valid1_d;
   logic                  sync1_q,       sync1_d;
   logic                  supp1_q,       supp1_d;
   logic                  bypass1_q,     bypass1_d;

   // ---------------- stage 2 (outputs) ----------------
   logic [DATA_WIDTH-1:0] dout_q,        dout_d;
   logic                  dout_valid_q,  dout_valid_d;
   logic                  sync_out_q,    sync_out_d;

   // ---------------- RAM ----------------
   logic [DATA_WIDTH-1:0] ram_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   // ---------------- combinational helpers ----------------
   logic                  req_changed_s;
   logic                  req_over_s;
   logic [ADDR_BITS-1:0]  req_clamped_s;
   logic                  apply_s;
   logic [ADDR_BITS-1:0]  delay_eff_s;
   logic [ADDR_BITS-1:0]  fill_eff_s;
   logic [ADDR_BITS-1:0]  rd_addr_s;
   logic                  suppress_s;
   logic                  bypass_s;

   // Decode the request and the delay/fill values governing this cycle's sample
   always_comb begin
      req_changed_s = (req_q != req_prev_q);
      req_over_s    = |req_q[31:ADDR_BITS];
      if (req_over_s) begin
         req_clamped_s = MAX_DELAY;
      end else begin
         req_clamped_s = req_q[ADDR_BITS-1:0];
      end
      apply_s = bus.sync_in & bus.din_valid & pending_q;
      // The sync sample itself already uses the newly applied delay and
      // a cleared fill count.
      if (apply_s) begin
         delay_eff_s = pending_val_q;
         fill_eff_s  = ZERO;
      end else begin
         delay_eff_s = active_q;
         fill_eff_s  = fill_q;
      end
      rd_addr_s  = wr_ptr_q - delay_eff_s;
      suppress_s = (fill_eff_s < delay_eff_s);
      bypass_s   = (delay_eff_s == ZERO);
   end

   // Delay request capture, pending/err bookkeeping and apply on sync
   always_comb begin
      req_d         = bus.delay_reg;
      req_prev_d    = req_q;
      pending_val_d = pending_val_q;
      pending_d     = pending_q;
      err_d         = err_q;
      active_d      = active_q;
      // A request change wins the pending slot even when a sync applies
      // the previously pending value in the same cycle.
      if (req_changed_s) begin
         pending_val_d = req_clamped_s;
         pending_d     = 1'b1;
         err_d         = req_over_s;
      end else if (apply_s) begin
         pending_d     = 1'b0;
      end else begin
         pending_d     = pending_q;
      end
      if (apply_s) begin
         active_d = pending_val_q;
      end else begin
         active_d = active_q;
      end
   end

   // Write pointer and saturating fill count advance only on valid samples
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      fill_d   = fill_q;
      if (bus.din_valid) begin
         wr_ptr_d = wr_ptr_q + ONE;
         if (fill_eff_s == MAX_DELAY) begin
            fill_d = MAX_DELAY;
         end else begin
            fill_d = fill_eff_s + ONE;
         end
      end else begin
         wr_ptr_d = wr_ptr_q;
         fill_d   = fill_q;
      end
   end

   // Stage 1 carries sample, valid, sync and output-select decisions beside the RAM read
   always_comb begin
      din1_d    = bus.din;
      valid1_d  = bus.din_valid;
      sync1_d   = bus.sync_in;
      supp1_d   = suppress_s;
      bypass1_d = bypass_s;
   end

   // Stage 2 selects zero (unfilled), bypass (delay 0) or RAM data
   always_comb begin
      dout_d       = dout_q;
      dout_valid_d = valid1_q;
      sync_out_d   = sync1_q;
      if (valid1_q) begin
         if (supp1_q) begin
            dout_d = {DATA_WIDTH{1'b0}};
         end else if (bypass1_q) begin
            dout_d = din1_q;
         end else begin
            dout_d = rd_data_q;
         end
      end else begin
         dout_d = dout_q;
      end
   end

   // Circular sample buffer: write on valid, registered read every cycle (read-before-write)
   always_ff @(posedge user_clk) begin
      if (bus.din_valid) begin
         ram_q[wr_ptr_q] <= bus.din;
      end
      rd_data_q <= ram_q[rd_addr_s];
   end

   // Control and pipeline registers with asynchronous clear
   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         req_q         <= 32'd0;
         req_prev_q    <= 32'd0;
         pending_val_q <= ZERO;
         pending_q     <= 1'b0;
         err_q         <= 1'b0;
         active_q      <= ZERO;
         wr_ptr_q      <= ZERO;
         fill_q        <= ZERO;
         din1_q        <= {DATA_WIDTH{1'b0}};
         valid1_q      <= 1'b0;
         sync1_q       <= 1'b0;
         supp1_q       <= 1'b0;
         bypass1_q     <= 1'b0;
         dout_q        <= {DATA_WIDTH{1'b0}};
         dout_valid_q  <= 1'b0;
         sync_out_q    <= 1'b0;
      end else begin
         req_q         <= req_d;
         req_prev_q    <= req_prev_d;
         pending_val_q <= pending_val_d;
         pending_q     <= pending_d;
         err_q         <= err_d;
         active_q      <= active_d;
         wr_ptr_q      <= wr_ptr_d;
         fill_q        <= fill_d;
         din1_q        <= din1_d;
         valid1_q      <= valid1_d;
         sync1_q       <= sync1_d;
         supp1_q       <= supp1_d;
         bypass1_q     <= bypass1_d;
         dout_q        <= dout_d;
         dout_valid_q  <= dout_valid_d;
         sync_out_q    <= sync_out_d;
      end
   end

   // All outputs come straight from registers
   always_comb begin
      bus.dout          = dout_q;
      bus.dout_valid    = dout_valid_q;
      bus.sync_out      = sync_out_q;
      bus.delay_active  = active_q;
      bus.delay_pending = pending_q;
      bus.delay_err     = err_q;
   end

endmodule

// File: tb/tb_coarse_delay_buffer.sv
// Directed bench for coarse_delay_buffer: ramp stream, delay programming,
// clamping with buffer wrap, sync/change collision, gapped valid and
// mid-stream reset. Expected outputs are the ramp value minus the delay
// the bench has programmed, or zero inside the post-sync fill window.
module tb_coarse_delay_buffer;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   // one-sample expectation carried across the two-cycle latency
   logic        pv;
   logic        ps;
   logic [31:0] pe;
   // bench model: ramp value, valid samples since last applied sync, delay
   logic [31:0] vcnt;
   int          k;
   int          dly;

   coarse_delay_buffer_if #(.ADDR_BITS(10), .DATA_WIDTH(32)) bus ();

   coarse_delay_buffer #(.ADDR_BITS(10), .DATA_WIDTH(32)) dut (
      .user_clk   (clk),
      .user_rst_n (rst_n),
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one cycle of input, clock it, then check the previous cycle's output
   task automatic send(input logic v, input logic s, input logic [31:0] d, input logic [31:0] e);
      bus.din_valid = v;
      bus.sync_in   = s;
      bus.din       = d;
      @(posedge clk);
      #1;
      chk("dout_valid", 64'(bus.dout_valid), 64'(pv));
      chk("sync_out", 64'(bus.sync_out), 64'(ps));
      if (pv) chk("dout", 64'(bus.dout), 64'(pe));
      pv = v;
      ps = s;
      pe = e;
   endtask

   // Valid ramp sample; 'applies' marks a sync the bench knows will take effect
   task automatic vsample(input logic s, input logic applies, input int newd);
      logic [31:0] e;
      if (applies) begin
         dly = newd;
         k   = 0;
      end
      if (k < dly) e = 32'd0;
      else         e = vcnt - 32'(dly);
      send(1'b1, s, vcnt, e);
      vcnt = vcnt + 32'd1;
      if (k < 100000) k++;
   endtask

   task automatic idle();
      send(1'b0, 1'b0, 32'hDEAD_BEEF, 32'd0);
   endtask

   task automatic status(input string tag, input int act, input logic pend, input logic err);
      chk({tag, "_active"}, 64'(bus.delay_active), 64'(act));
      chk({tag, "_pending"}, 64'(bus.delay_pending), 64'(pend));
      chk({tag, "_err"}, 64'(bus.delay_err), 64'(err));
   endtask

   initial begin
      checks = 0; errors = 0;
      pv = 1'b0; ps = 1'b0; pe = 32'd0;
      vcnt = 32'd0; k = 0; dly = 0;
      rst_n = 1'b0;
      bus.delay_reg = 32'd0;
      bus.sync_in   = 1'b0;
      bus.din       = 32'd0;
      bus.din_valid = 1'b0;

      // reset state
      #23;
      chk("rst_dout", 64'(bus.dout), 64'd0);
      chk("rst_dout_valid", 64'(bus.dout_valid), 64'd0);
      chk("rst_sync_out", 64'(bus.sync_out), 64'd0);
      status("rst", 0, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // delay 0: straight ramp, sync passes through aligned
      for (int i = 0; i < 20; i++) vsample((i == 10) ? 1'b1 : 1'b0, 1'b0, 0);
      status("d0", 0, 1'b0, 1'b0);

      // delay 5: pending two cycles after the register write, applied on sync
      bus.delay_reg = 32'd5;
      vsample(1'b0, 1'b0, 0);
      chk("d5_pend_early", 64'(bus.delay_pending), 64'd0);
      vsample(1'b0, 1'b0, 0);
      status("d5_pend", 0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) vsample(1'b0, 1'b0, 0);
      chk("d5_still_pend", 64'(bus.delay_pending), 64'd1);
      vsample(1'b1, 1'b1, 5);
      status("d5_applied", 5, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) vsample(1'b0, 1'b0, 0);

      // oversized request clamps to 1023; run past two buffer wraps
      bus.delay_reg = 32'h0000_0400;
      vsample(1'b0, 1'b0, 0);
      vsample(1'b0, 1'b0, 0);
      status("clamp_pend", 5, 1'b1, 1'b1);
      vsample(1'b1, 1'b1, 1023);
      status("clamp_applied", 1023, 1'b0, 1'b1);
      for (int i = 0; i < 2100; i++) vsample(1'b0, 1'b0, 0);
      bus.delay_reg = 32'd3;
      vsample(1'b0, 1'b0, 0);
      vsample(1'b0, 1'b0, 0);
      status("d3_pend", 1023, 1'b1, 1'b0);
      vsample(1'b1, 1'b1, 3);
      status("d3_applied", 3, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) vsample(1'b0, 1'b0, 0);

      // request change detected in the very cycle of a sync: old pending wins
      bus.delay_reg = 32'd6;
      vsample(1'b0, 1'b0, 0);
      vsample(1'b0, 1'b0, 0);
      for (int i = 0; i < 5; i++) vsample(1'b0, 1'b0, 0);
      bus.delay_reg = 32'd9;
      vsample(1'b0, 1'b0, 0);
      vsample(1'b1, 1'b1, 6);
      status("collide", 6, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) vsample(1'b0, 1'b0, 0);
      vsample(1'b1, 1'b1, 9);
      status("collide_next", 9, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) vsample(1'b0, 1'b0, 0);

      // delay 4 with 1-on/2-off valid pattern
      bus.delay_reg = 32'd4;
      vsample(1'b0, 1'b0, 0);
      vsample(1'b0, 1'b0, 0);
      vsample(1'b1, 1'b1, 4);
      status("gap", 4, 1'b0, 1'b0);
      for (int i = 0; i < 36; i++) begin
         if (i % 3 == 0) vsample(1'b0, 1'b0, 0);
         else            idle();
      end

      // delay 7 then asynchronous reset mid-cycle
      bus.delay_reg = 32'd7;
      vsample(1'b0, 1'b0, 0);
      vsample(1'b0, 1'b0, 0);
      vsample(1'b1, 1'b1, 7);
      status("d7", 7, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) vsample(1'b0, 1'b0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_dout", 64'(bus.dout), 64'd0);
      chk("mrst_dout_valid", 64'(bus.dout_valid), 64'd0);
      chk("mrst_sync_out", 64'(bus.sync_out), 64'd0);
      status("mrst", 0, 1'b0, 1'b0);
      bus.din_valid = 1'b0;
      bus.sync_in   = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      pv = 1'b0; ps = 1'b0; pe = 32'd0;
      dly = 0; k = 0;
      // after reset: bypass behaviour, register value 7 re-detected as pending
      for (int i = 0; i < 12; i++) vsample(1'b0, 1'b0, 0);
      status("post_rst", 0, 1'b1, 1'b0);
      vsample(1'b1, 1'b1, 7);
      status("post_rst_applied", 7, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) vsample(1'b0, 1'b0, 0);
      idle();
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/coarse_delay_buffer.md
# coarse_delay_buffer

Integer-sample coarse delay stage in the `user_clk` domain, driven by the 32-bit coarse-delay software register output (`user_data_out`) of the OPB register block. It delays a 32-bit sample stream by a software-programmed number of valid samples using a circular BRAM buffer. Delay changes take effect only on a sync pulse, keeping all channels in the F-engine aligned. It feeds the downstream fine-delay and FFT stages.

## Interface
- `ADDR_BITS`, 10: buffer depth 2^ADDR_BITS words; maximum delay 2^ADDR_BITS-1.
- `DATA_WIDTH`, 32: sample word width.
- `user_clk` in 1: sole clock; all logic on the rising edge.
- `user_rst_n` in 1: reset, asynchronous, active-low.
- `delay_reg` in 32: coarse-delay register value, unsigned sample count.
- `sync_in` in 1: one-cycle frame sync, qualified by `din_valid`.
- `din` in DATA_WIDTH: input sample.
- `din_valid` in 1: `din` is valid this cycle.
- `dout` out DATA_WIDTH: delayed sample.
- `dout_valid` out 1: `dout` is valid.
- `sync_out` out 1: `sync_in` delayed by the pipeline latency.
- `delay_active` out ADDR_BITS: delay currently applied.
- `delay_pending` out 1: a new delay has been latched and awaits sync.
- `delay_err` out 1: the requested delay exceeded the maximum and was clamped.

## Operation
- Buffer: dual-port RAM, 2^ADDR_BITS x DATA_WIDTH. Write port at `wr_ptr`; `wr_ptr` increments modulo 2^ADDR_BITS on each `din_valid`.
- Read address: `wr_ptr - delay_active`, computed modulo 2^ADDR_BITS (natural wrap). It is issued in the same cycle as the write.
- Delay capture: `delay_reg` is registered every cycle into `req_q`. When `req_q` differs from its previous value, the block:
  - clamps the value to 2^ADDR_BITS-1 if any bit at or above ADDR_BITS is set, and sets `delay_err`;
  - otherwise clears `delay_err`;
  - loads `pending_val` and sets `delay_pending`.
- Apply: on a cycle with `sync_in & din_valid & delay_pending`, the block loads `delay_active <= pending_val`, clears `delay_pending`, and clears the fill counter. The new delay governs the sync sample itself.
- Simultaneous register change and sync in the same cycle: the sync applies the old `pending_val`. The new value becomes pending and waits for the next sync.
- Fill counter: saturating at 2^ADDR_BITS-1, incremented on each `din_valid`.
  - While fill < `delay_active`, `dout` is forced to 0 (stale-data suppression). `dout_valid` still asserts.
  - Reset clears the fill counter.
- Delay 0: a bypass path selects the registered `din` instead of RAM read data. This avoids the read-during-write hazard.
- `din_valid` low: no write, no pointer or fill advance; `dout_valid` goes low 2 cycles later.

## Timing
- Pipeline latency: 2 cycles, fixed (RAM read register plus output register). `dout_valid` and `sync_out` equal `din_valid` and `sync_in` delayed by 2 cycles.
- Sample delay: `dout` at valid output k equals `din` at valid input k - `delay_active`.
- `delay_reg` to `delay_pending` high: 2 cycles (register, then compare).
- `delay_active` update: visible the cycle after the qualifying sync.
- Reset values (asynchronous, on `user_rst_n` low):
  - `dout`=0, `dout_valid`=0, `sync_out`=0;
  - `delay_active`=0, `delay_pending`=0, `delay_err`=0;
  - `wr_ptr`=0, fill=0, `req_q`=0.
  - RAM contents are not reset; the fill-counter suppression covers this.
- Reset mid-stream: the pipeline is flushed; the first output after reset returns to the 0-delay bypass behaviour until a sync applies a pending delay.
- Delay wrap: `wr_ptr` wrap-around with delay 2^ADDR_BITS-1 reads the oldest word without glitching.

## Test plan
- Reset, continuous `din_valid`, `din`=ramp 0,1,2..., `delay_reg`=0 -> `dout`=`din` after 2 cycles; `sync_out` aligned with the delayed sync.
- Write `delay_reg`=5, then pulse sync -> `delay_pending` high until sync. After sync:
  - first 5 outputs are 0;
  - then `dout` = ramp value minus 5;
  - `delay_active`=5.
- `delay_reg`=0x400 with ADDR_BITS=10 -> `delay_err`=1, `delay_active`=1023 after sync. Run more than 2048 samples and check wrap-around correctness. Then write 3 -> `delay_err` clears.
- Change `delay_reg` in the same cycle as sync -> the old pending value is applied. The new value stays pending and is applied on the next sync.
- Gap `din_valid` in a 1-on/2-off pattern with delay 4 -> output equals input delayed by 4 valid samples; `dout_valid` pattern matches the input pattern shifted by 2 cycles.
- Assert `user_rst_n` low mid-stream with delay 7 -> all outputs go to 0 immediately. After release, `delay_active`=0 and no stale RAM data appears on `dout`.
